// File: rtl/jcu_seq_if.sv
`timescale 1ns/1ps
// Control-unit boundary: IR/flags/IO-ack in, datapath strobes and step bus out.
// Handshake: io_req is held high until the cycle io_ack is seen with it; that cycle completes the transfer.
interface jcu_seq_if #(
  parameter int NREGS = 4,
  parameter int STEPS = 6
);
  localparam int RB   = $clog2(NREGS);
  localparam int IR_W = 4 + 2 * RB;

  logic [0:IR_W-1]  ir_bus;
  logic             flags_co;
  logic             flags_alo;
  logic             flags_eqo;
  logic             flags_z;
  logic             io_ack;
  logic [STEPS-1:0] STP_bus;
  logic [2:0]       alu_op;
  logic             alu_ena_ci;
  logic             flags_s;
  logic             tmp_s;
  logic             bus1_bit1;
  logic             acc_s;
  logic             acc_e;
  logic [NREGS-1:0] reg_s;
  logic [NREGS-1:0] reg_e;
  logic             ram_mar_s;
  logic             ram_s;
  logic             ram_e;
  logic             iar_s;
  logic             iar_e;
  logic             ir_s;
  logic             io_req;
  logic             io_out;
  logic             io_da;
  logic             halted;
  logic [1:0]       dbg_state;

  modport master (
    input  ir_bus, flags_co, flags_alo, flags_eqo, flags_z, io_ack,
    output STP_bus, alu_op, alu_ena_ci, flags_s, tmp_s, bus1_bit1, acc_s, acc_e,
           reg_s, reg_e, ram_mar_s, ram_s, ram_e, iar_s, iar_e, ir_s,
           io_req, io_out, io_da, halted, dbg_state
  );

  modport slave (
    output ir_bus, flags_co, flags_alo, flags_eqo, flags_z, io_ack,
    input  STP_bus, alu_op, alu_ena_ci, flags_s, tmp_s, bus1_bit1, acc_s, acc_e,
           reg_s, reg_e, ram_mar_s, ram_s, ram_e, iar_s, iar_e, ir_s,
           io_req, io_out, io_da, halted, dbg_state
  );
endinterface

// File: rtl/jcu_seq.sv
`timescale 1ns/1ps
// Single-clock jcscpu control unit: step counter plus full ISA strobe decode,
// with an IO req/ack stall state and a HALTED state left only through reset.
module jcu_seq #(
  parameter int NREGS = 4,
  parameter int STEPS = 6
) (
  input logic        CLK_clk,
  input logic        CLK_rst_n,
  jcu_seq_if.master  bus
);
  localparam int RB = $clog2(NREGS);
  localparam int SW = $clog2(STEPS);

  localparam logic [SW-1:0] S0    = SW'(0);
  localparam logic [SW-1:0] S1    = SW'(1);
  localparam logic [SW-1:0] S2    = SW'(2);
  localparam logic [SW-1:0] S3    = SW'(3);
  localparam logic [SW-1:0] S4    = SW'(4);
  localparam logic [SW-1:0] S5    = SW'(5);
  localparam logic [SW-1:0] SLAST = SW'(STEPS - 1);

  typedef enum logic [1:0] {RUN = 2'd0, IOWAIT = 2'd1, HALTED = 2'd2} state_t;

  state_t        state, state_next;
  logic [SW-1:0] step, step_next, step_adv;

  logic          is_alu, is_io, is_halt, jump_ok, in_io, fetch0;
  logic [2:0]    op;
  logic [3:0]    sub;
  logic [RB-1:0] ra, rb;
  logic [SW-1:0] io_step;

  assign is_alu   = bus.ir_bus[0];
  assign op       = bus.ir_bus[1:3];
  assign sub      = bus.ir_bus[4:7];
  assign ra       = bus.ir_bus[4 +: RB];
  assign rb       = bus.ir_bus[4+RB +: RB];
  assign is_io    = !is_alu && (op == 3'b111);
  assign is_halt  = !is_alu && (op == 3'b110) && (sub == 4'b0001);
  assign jump_ok  = (sub[3] & bus.flags_co) | (sub[2] & bus.flags_alo) |
                    (sub[1] & bus.flags_eqo) | (sub[0] & bus.flags_z);
  // Output transfers happen at step 3, input transfers at step 4.
  assign io_step  = bus.ir_bus[4] ? S3 : S4;
  assign in_io    = (state == IOWAIT) || (is_io && (state == RUN) && (step == io_step));
  assign step_adv = (step == SLAST) ? '0 : step + SW'(1);
  assign bus.dbg_state = state;

  always_ff @(posedge CLK_clk) begin
    if (!CLK_rst_n) begin
      state <= RUN;
      step  <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
    end
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    case (state)
      RUN: begin
        step_next = step_adv;
        if (in_io && !bus.io_ack) begin
          state_next = IOWAIT;
          step_next  = step;
        end else if (is_halt && (step == S5)) begin
          state_next = HALTED;
          step_next  = '0;
        end
      end
      IOWAIT: begin
        if (bus.io_ack) begin
          state_next = RUN;
          step_next  = step_adv;
        end
      end
      HALTED: ;
      default: begin
        state_next = RUN;
        step_next  = '0;
      end
    endcase
  end

  // All strobes are forced low combinationally while reset is held.
  always_comb begin
    bus.STP_bus    = '0;
    bus.alu_op     = '0;
    bus.alu_ena_ci = 1'b0;
    bus.flags_s    = 1'b0;
    bus.tmp_s      = 1'b0;
    bus.bus1_bit1  = 1'b0;
    bus.acc_s      = 1'b0;
    bus.acc_e      = 1'b0;
    bus.reg_s      = '0;
    bus.reg_e      = '0;
    bus.ram_mar_s  = 1'b0;
    bus.ram_s      = 1'b0;
    bus.ram_e      = 1'b0;
    bus.iar_s      = 1'b0;
    bus.iar_e      = 1'b0;
    bus.ir_s       = 1'b0;
    bus.io_req     = 1'b0;
    bus.io_out     = 1'b0;
    bus.io_da      = 1'b0;
    bus.halted     = 1'b0;
    fetch0         = 1'b0;
    if (CLK_rst_n) begin
      bus.halted = (state == HALTED);
      if (state != HALTED) bus.STP_bus = STEPS'(1) << step;
      if (state == RUN) begin
        case (step)
          S0: fetch0 = 1'b1;
          S1: begin bus.ram_e = 1'b1; bus.ir_s = 1'b1; end
          S2: begin bus.acc_e = 1'b1; bus.iar_s = 1'b1; end
          S3: begin
            if (is_alu) begin
              bus.reg_e[rb] = 1'b1;
              bus.tmp_s     = 1'b1;
            end else begin
              case (op)
                3'b000, 3'b001: begin bus.reg_e[ra] = 1'b1; bus.ram_mar_s = 1'b1; end
                3'b010, 3'b101: fetch0 = 1'b1;
                3'b011: begin bus.reg_e[rb] = 1'b1; bus.iar_s = 1'b1; end
                3'b100: begin bus.iar_e = 1'b1; bus.ram_mar_s = 1'b1; end
                3'b110: if (sub == 4'b0000) begin bus.bus1_bit1 = 1'b1; bus.flags_s = 1'b1; end
                default: ;
              endcase
            end
          end
          S4: begin
            if (is_alu) begin
              bus.reg_e[ra]  = 1'b1;
              bus.alu_ena_ci = 1'b1;
              bus.acc_s      = 1'b1;
              bus.flags_s    = 1'b1;
              bus.alu_op     = op;
            end else begin
              case (op)
                3'b000, 3'b010: begin bus.ram_e = 1'b1; bus.reg_s[rb] = 1'b1; end
                3'b001: begin bus.reg_e[rb] = 1'b1; bus.ram_s = 1'b1; end
                3'b100: begin bus.ram_e = 1'b1; bus.iar_s = 1'b1; end
                3'b101: begin bus.acc_e = 1'b1; bus.iar_s = 1'b1; end
                default: ;
              endcase
            end
          end
          S5: begin
            if (is_alu) begin
              if (op != 3'b111) begin bus.acc_e = 1'b1; bus.reg_s[rb] = 1'b1; end
            end else if (op == 3'b010) begin
              bus.acc_e = 1'b1;
              bus.iar_s = 1'b1;
            end else if ((op == 3'b101) && jump_ok) begin
              bus.ram_e = 1'b1;
              bus.iar_s = 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (fetch0) begin
        bus.bus1_bit1 = 1'b1;
        bus.iar_e     = 1'b1;
        bus.ram_mar_s = 1'b1;
        bus.acc_s     = 1'b1;
      end
      if (in_io) begin
        bus.io_req = 1'b1;
        bus.io_out = bus.ir_bus[4];
        bus.io_da  = bus.ir_bus[5];
        if (bus.ir_bus[4]) bus.reg_e[rb] = 1'b1;
        else if (bus.io_ack) bus.reg_s[rb] = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_jcu_seq.sv
`timescale 1ns/1ps
// Directed bench for jcu_seq: per-cycle expected strobe snapshots go through a queue
// and are compared at the falling edge; a second NREGS=8 instance checks register select.
module tb_jcu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jcu_seq_if #(.NREGS(4), .STEPS(6)) bus4 ();
  jcu_seq_if #(.NREGS(8), .STEPS(6)) bus8 ();

  jcu_seq #(.NREGS(4), .STEPS(6)) dut4 (.CLK_clk(clk), .CLK_rst_n(rst_n), .bus(bus4));
  jcu_seq #(.NREGS(8), .STEPS(6)) dut8 (.CLK_clk(clk), .CLK_rst_n(rst_n), .bus(bus8));

  typedef struct packed {
    logic [5:0] stp;
    logic [2:0] alu_op;
    logic       alu_ena_ci, flags_s, tmp_s, bus1_bit1, acc_s, acc_e;
    logic [3:0] reg_s, reg_e;
    logic       ram_mar_s, ram_s, ram_e, iar_s, iar_e, ir_s;
    logic       io_req, io_out, io_da, halted;
  } obs_t;

  localparam int OW = $bits(obs_t);
  logic [OW-1:0] exp_q[$];
  logic [15:0]   exp8_q[$];
  int checks = 0;
  int errors = 0;
  obs_t e;

  function automatic obs_t sample();
    obs_t o;
    o.stp = bus4.STP_bus;         o.alu_op = bus4.alu_op;
    o.alu_ena_ci = bus4.alu_ena_ci; o.flags_s = bus4.flags_s;
    o.tmp_s = bus4.tmp_s;         o.bus1_bit1 = bus4.bus1_bit1;
    o.acc_s = bus4.acc_s;         o.acc_e = bus4.acc_e;
    o.reg_s = bus4.reg_s;         o.reg_e = bus4.reg_e;
    o.ram_mar_s = bus4.ram_mar_s; o.ram_s = bus4.ram_s;
    o.ram_e = bus4.ram_e;         o.iar_s = bus4.iar_s;
    o.iar_e = bus4.iar_e;         o.ir_s = bus4.ir_s;
    o.io_req = bus4.io_req;       o.io_out = bus4.io_out;
    o.io_da = bus4.io_da;         o.halted = bus4.halted;
    return o;
  endfunction

  function automatic obs_t st(input int s);
    obs_t o;
    o = '0;
    o.stp = 6'b000001 << s;
    return o;
  endfunction

  function automatic obs_t f0at(input int s);
    obs_t o;
    o = st(s);
    o.bus1_bit1 = 1'b1; o.iar_e = 1'b1; o.ram_mar_s = 1'b1; o.acc_s = 1'b1;
    return o;
  endfunction

  task automatic cyc(input string tag, input obs_t exp_v);
    obs_t          act;
    logic [OW-1:0] want;
    logic [15:0]   want8, act8;
    exp_q.push_back(exp_v);
    @(negedge clk);
    act  = sample();
    want = exp_q.pop_front();
    checks++;
    assert (act === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, act, want);
    end
    if (exp8_q.size() != 0) begin
      want8 = exp8_q.pop_front();
      act8  = {bus8.reg_s, bus8.reg_e};
      checks++;
      assert (act8 === want8) else begin
        errors++;
        $error("FAIL %s_n8: observed %h expected %h", tag, act8, want8);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch3(input string tag);
    obs_t o;
    cyc({tag, "_s0"}, f0at(0));
    o = st(1); o.ram_e = 1'b1; o.ir_s = 1'b1;
    cyc({tag, "_s1"}, o);
    o = st(2); o.acc_e = 1'b1; o.iar_s = 1'b1;
    cyc({tag, "_s2"}, o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus4.ir_bus = 8'h00;
    bus4.flags_co = 1'b0; bus4.flags_alo = 1'b0; bus4.flags_eqo = 1'b0; bus4.flags_z = 1'b0;
    bus4.io_ack = 1'b0;
    bus8.ir_bus = 10'b1_000_011_101;
    bus8.flags_co = 1'b0; bus8.flags_alo = 1'b0; bus8.flags_eqo = 1'b0; bus8.flags_z = 1'b0;
    bus8.io_ack = 1'b0;

    cyc("reset_zero", '0);
    rst_n = 1'b1;

    // LD r0,r0 on the 4-reg core; ADD r3,r5 on the 8-reg core in lockstep
    exp8_q.push_back(16'h0000); exp8_q.push_back(16'h0000); exp8_q.push_back(16'h0000);
    exp8_q.push_back(16'h0020); exp8_q.push_back(16'h0008); exp8_q.push_back(16'h2000);
    fetch3("ld");
    e = st(3); e.reg_e = 4'b0001; e.ram_mar_s = 1'b1; cyc("ld_s3", e);
    e = st(4); e.ram_e = 1'b1; e.reg_s = 4'b0001;     cyc("ld_s4", e);
    cyc("ld_s5", st(5));

    bus4.ir_bus = 8'b1000_0110;
    fetch3("add_wrap");
    e = st(3); e.reg_e = 4'b0100; e.tmp_s = 1'b1; cyc("add_s3", e);
    e = st(4); e.reg_e = 4'b0010; e.alu_ena_ci = 1'b1; e.acc_s = 1'b1; e.flags_s = 1'b1;
    cyc("add_s4", e);
    e = st(5); e.acc_e = 1'b1; e.reg_s = 4'b0100; cyc("add_s5", e);

    bus4.ir_bus = 8'b1111_0110;
    fetch3("cmp");
    e = st(3); e.reg_e = 4'b0100; e.tmp_s = 1'b1; cyc("cmp_s3", e);
    e = st(4); e.reg_e = 4'b0010; e.alu_ena_ci = 1'b1; e.acc_s = 1'b1; e.flags_s = 1'b1;
    e.alu_op = 3'b111; cyc("cmp_s4", e);
    cyc("cmp_s5", st(5));

    bus4.ir_bus = 8'b0001_1011;
    fetch3("st");
    e = st(3); e.reg_e = 4'b0100; e.ram_mar_s = 1'b1; cyc("st_s3", e);
    e = st(4); e.reg_e = 4'b1000; e.ram_s = 1'b1;     cyc("st_s4", e);
    cyc("st_s5", st(5));

    bus4.ir_bus = 8'b0010_0001;
    fetch3("data");
    cyc("data_s3", f0at(3));
    e = st(4); e.ram_e = 1'b1; e.reg_s = 4'b0010; cyc("data_s4", e);
    e = st(5); e.acc_e = 1'b1; e.iar_s = 1'b1;    cyc("data_s5", e);

    bus4.ir_bus = 8'b0011_0010;
    fetch3("jmpr");
    e = st(3); e.reg_e = 4'b0100; e.iar_s = 1'b1; cyc("jmpr_s3", e);
    cyc("jmpr_s4", st(4)); cyc("jmpr_s5", st(5));

    bus4.ir_bus = 8'b0100_0000;
    fetch3("jmp");
    e = st(3); e.iar_e = 1'b1; e.ram_mar_s = 1'b1; cyc("jmp_s3", e);
    e = st(4); e.ram_e = 1'b1; e.iar_s = 1'b1;     cyc("jmp_s4", e);
    cyc("jmp_s5", st(5));

    // stray io_ack outside an IO instruction must have no effect
    bus4.ir_bus = 8'b0110_0000;
    bus4.io_ack = 1'b1;
    fetch3("clf");
    e = st(3); e.bus1_bit1 = 1'b1; e.flags_s = 1'b1; cyc("clf_s3", e);
    cyc("clf_s4", st(4)); cyc("clf_s5", st(5));
    bus4.io_ack = 1'b0;

    bus4.ir_bus = 8'b0101_0010;
    bus4.flags_eqo = 1'b1;
    fetch3("jif_t");
    cyc("jif_t_s3", f0at(3));
    e = st(4); e.acc_e = 1'b1; e.iar_s = 1'b1; cyc("jif_t_s4", e);
    e = st(5); e.ram_e = 1'b1; e.iar_s = 1'b1; cyc("jif_t_s5", e);
    bus4.flags_eqo = 1'b0; bus4.flags_z = 1'b1;
    fetch3("jif_f");
    cyc("jif_f_s3", f0at(3));
    e = st(4); e.acc_e = 1'b1; e.iar_s = 1'b1; cyc("jif_f_s4", e);
    cyc("jif_f_s5", st(5));
    bus4.ir_bus = 8'b0101_0000;
    bus4.flags_co = 1'b1; bus4.flags_alo = 1'b1; bus4.flags_eqo = 1'b1;
    fetch3("jif_m0");
    cyc("jif_m0_s3", f0at(3));
    e = st(4); e.acc_e = 1'b1; e.iar_s = 1'b1; cyc("jif_m0_s4", e);
    cyc("jif_m0_s5", st(5));
    bus4.flags_co = 1'b0; bus4.flags_alo = 1'b0; bus4.flags_eqo = 1'b0; bus4.flags_z = 1'b0;

    // IO output, ack on the fourth request cycle
    bus4.ir_bus = 8'b0111_1001;
    fetch3("iow");
    e = st(3); e.io_req = 1'b1; e.io_out = 1'b1; e.reg_e = 4'b0010;
    for (int i = 0; i < 3; i++) cyc("iow_wait", e);
    bus4.io_ack = 1'b1;
    cyc("iow_ack", e);
    bus4.io_ack = 1'b0;
    cyc("iow_s4", st(4)); cyc("iow_s5", st(5));

    fetch3("iow0");
    bus4.io_ack = 1'b1;
    cyc("iow0_ack", e);
    bus4.io_ack = 1'b0;
    cyc("iow0_s4", st(4)); cyc("iow0_s5", st(5));

    // IO input: write strobe only in the ack cycle
    bus4.ir_bus = 8'b0111_0110;
    fetch3("ior");
    cyc("ior_s3", st(3));
    e = st(4); e.io_req = 1'b1; e.io_da = 1'b1;
    cyc("ior_wait", e);
    bus4.io_ack = 1'b1;
    e.reg_s = 4'b0100;
    cyc("ior_ack", e);
    bus4.io_ack = 1'b0;
    cyc("ior_s5", st(5));

    // reset in the middle of an IO wait
    bus4.ir_bus = 8'b0111_1001;
    fetch3("iorst");
    e = st(3); e.io_req = 1'b1; e.io_out = 1'b1; e.reg_e = 4'b0010;
    cyc("iorst_wait", e); cyc("iorst_wait", e);
    rst_n = 1'b0;
    cyc("iorst_zero", '0);
    rst_n = 1'b1;
    bus4.ir_bus = 8'b0110_0001;
    fetch3("halt");
    cyc("halt_s3", st(3)); cyc("halt_s4", st(4)); cyc("halt_s5", st(5));
    e = '0; e.halted = 1'b1;
    for (int i = 0; i < 4; i++) cyc("halted", e);
    rst_n = 1'b0;
    cyc("halt_rst", '0);
    rst_n = 1'b1;
    bus4.ir_bus = 8'h00;
    fetch3("post_halt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
